// File: rtl/m_dmux4way16_buf.sv
// Registered 4-way demultiplexer: steers one valid/ready word per cycle into one of four
// single-entry output slots. Define DMUX4WAY16_COUNT_EN to build per-slot drain counters.
module m_dmux4way16_buf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_sel1,
  input  logic             i_sel2,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [WIDTH-1:0] o_c,
  output logic [WIDTH-1:0] o_d,
  output logic             o_valid_a,
  output logic             o_valid_b,
  output logic             o_valid_c,
  output logic             o_valid_d,
  input  logic             i_ready_a,
  input  logic             i_ready_b,
  input  logic             i_ready_c,
  input  logic             i_ready_d,
  output logic [15:0]      o_cnt_a,
  output logic [15:0]      o_cnt_b,
  output logic [15:0]      o_cnt_c,
  output logic [15:0]      o_cnt_d
);

  logic [1:0]       w_sel;
  logic [3:0]       w_ready_out;
  logic [3:0]       w_load;
  logic [3:0]       w_drain;
  logic             w_accept;
  logic [3:0]       r_valid;
  logic [WIDTH-1:0] r_data [4];

  assign w_sel       = {i_sel1, i_sel2};
  assign w_ready_out = {i_ready_d, i_ready_c, i_ready_b, i_ready_a};

  // A full slot can still accept when its consumer drains in the same cycle.
  assign o_ready  = ~r_valid[w_sel] | w_ready_out[w_sel];
  assign w_accept = i_valid & o_ready;
  assign w_drain  = r_valid & w_ready_out;

  always_comb begin
    w_load        = 4'b0000;
    w_load[w_sel] = w_accept;
  end

  for (genvar g = 0; g < 4; g++) begin : g_slot
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_valid[g] <= 1'b0;
        r_data[g]  <= '0;
      end else if (w_load[g]) begin
        r_valid[g] <= 1'b1;
        r_data[g]  <= i_in;
      end else if (w_drain[g]) begin
        r_valid[g] <= 1'b0;
      end
    end
  end

  assign o_a       = r_data[0];
  assign o_b       = r_data[1];
  assign o_c       = r_data[2];
  assign o_d       = r_data[3];
  assign o_valid_a = r_valid[0];
  assign o_valid_b = r_valid[1];
  assign o_valid_c = r_valid[2];
  assign o_valid_d = r_valid[3];

`ifdef DMUX4WAY16_COUNT_EN
  logic [15:0] r_cnt [4];

  // Counters wrap naturally at 16 bits and clear only on reset.
  for (genvar g = 0; g < 4; g++) begin : g_cnt
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt[g] <= 16'h0000;
      end else if (w_drain[g]) begin
        r_cnt[g] <= r_cnt[g] + 16'd1;
      end
    end
  end

  assign o_cnt_a = r_cnt[0];
  assign o_cnt_b = r_cnt[1];
  assign o_cnt_c = r_cnt[2];
  assign o_cnt_d = r_cnt[3];
`else
  assign o_cnt_a = 16'h0000;
  assign o_cnt_b = 16'h0000;
  assign o_cnt_c = 16'h0000;
  assign o_cnt_d = 16'h0000;
`endif

endmodule
